// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-requester arbiter/sequencer for a single-port data memory.
//            Round-robin by default; MEM_ARB_FIXED_PRIO_EN gives port 0 fixed priority.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
) (
    input  logic              m_clk,
    input  logic              m_rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [AWIDTH-1:0] r0_addr,
    input  logic [DWIDTH-1:0] r0_wdata,
    input  logic [3:0]        r0_mask,
    output logic              r0_ack,
    output logic [DWIDTH-1:0] r0_rdata,
    output logic              r0_rvalid,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [AWIDTH-1:0] r1_addr,
    input  logic [DWIDTH-1:0] r1_wdata,
    input  logic [3:0]        r1_mask,
    output logic              r1_ack,
    output logic [DWIDTH-1:0] r1_rdata,
    output logic              r1_rvalid,
    output logic              mem_ce,
    output logic              mem_wr_en,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic [3:0]        mem_mask,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    state_t            state_q;
    logic              gnt_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic              last_gnt_q;
`endif
    logic              r0_ack_q, r1_ack_q;
    logic              r0_rvalid_q, r1_rvalid_q;
    logic [DWIDTH-1:0] r0_rdata_q, r1_rdata_q;
    logic              mem_ce_q, mem_wr_en_q;
    logic [AWIDTH-1:0] mem_addr_q;
    logic [DWIDTH-1:0] mem_wdata_q;
    logic [3:0]        mem_mask_q;

    logic              gnt_d;
    logic              we_d;
    logic [AWIDTH-1:0] addr_d;
    logic [DWIDTH-1:0] wdata_d;
    logic [3:0]        mask_d;

    always_comb begin
        gnt_d = 1'b0;
        if (r0_req && r1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            gnt_d = 1'b0;
`else
            gnt_d = ~last_gnt_q;
`endif
        end else if (r1_req) begin
            gnt_d = 1'b1;
        end
    end

    assign we_d    = gnt_d ? r1_we    : r0_we;
    assign addr_d  = gnt_d ? r1_addr  : r0_addr;
    assign wdata_d = gnt_d ? r1_wdata : r0_wdata;
    assign mask_d  = gnt_d ? r1_mask  : r0_mask;

    always_ff @(posedge m_clk or posedge m_rst) begin
        if (m_rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_gnt_q  <= 1'b1;
`endif
            r0_ack_q    <= 1'b0;
            r1_ack_q    <= 1'b0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
            mem_ce_q    <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
        end else begin
            r0_ack_q    <= 1'b0;
            r1_ack_q    <= 1'b0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            mem_ce_q    <= 1'b0;
            mem_wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (r0_req || r1_req) begin
                        // Command fields are registered here so ACCESS drives them glitch-free.
                        gnt_q       <= gnt_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        last_gnt_q  <= gnt_d;
`endif
                        mem_ce_q    <= 1'b1;
                        mem_wr_en_q <= we_d;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
                        mem_mask_q  <= we_d ? mask_d : 4'b0000;
                        r0_ack_q    <= ~gnt_d;
                        r1_ack_q    <= gnt_d;
                        state_q     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    state_q <= mem_wr_en_q ? ST_IDLE : ST_RDWAIT;
                end
                ST_RDWAIT: begin
                    if (gnt_q) begin
                        r1_rdata_q  <= mem_rdata;
                        r1_rvalid_q <= 1'b1;
                    end else begin
                        r0_rdata_q  <= mem_rdata;
                        r0_rvalid_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign r0_ack    = r0_ack_q;
    assign r1_ack    = r1_ack_q;
    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r0_rdata  = r0_rdata_q;
    assign r1_rdata  = r1_rdata_q;
    assign mem_ce    = mem_ce_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_mask  = mem_mask_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter with a simple
//            byte-masked memory model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [9:0]  r0_addr = '0, r1_addr = '0;
    logic [31:0] r0_wdata = '0, r1_wdata = '0;
    logic [3:0]  r0_mask = '0, r1_mask = '0;
    logic        r0_ack, r1_ack, r0_rvalid, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_ce, mem_wr_en, busy;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;
    int ce_cnt = 0, r0_rv_cnt = 0, r1_rv_cnt = 0, r1_ack_cnt = 0;

    mem_port_arbiter #(.DWIDTH(32), .AWIDTH(10)) dut (
        .m_clk(clk), .m_rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_mask(r0_mask), .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_mask(r1_mask), .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
        .mem_ce(mem_ce), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_ce)    ce_cnt     <= ce_cnt + 1;
        if (r0_rvalid) r0_rv_cnt  <= r0_rv_cnt + 1;
        if (r1_rvalid) r1_rv_cnt  <= r1_rv_cnt + 1;
        if (r1_ack)    r1_ack_cnt <= r1_ack_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one transaction from port p starting at a negedge; returns the
    // negedge count to ack and to rvalid, plus {ce, wr_en, mask} at ack.
    task automatic txn(input bit p, input logic we, input logic [9:0] a,
                       input logic [31:0] d, input logic [3:0] m,
                       output int ack_cyc, output int rv_cyc, output logic [5:0] cmd);
        if (!p) begin
            r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d; r0_mask = m;
        end else begin
            r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d; r1_mask = m;
        end
        ack_cyc = 0;
        do begin
            @(negedge clk);
            ack_cyc++;
        end while (!(p ? r1_ack : r0_ack) && ack_cyc < 20);
        cmd = {mem_ce, mem_wr_en, mem_mask};
        if (!p) r0_req = 1'b0; else r1_req = 1'b0;
        rv_cyc = 0;
        if (!we) begin
            rv_cyc = ack_cyc;
            do begin
                @(negedge clk);
                rv_cyc++;
            end while (!(p ? r1_rvalid : r0_rvalid) && rv_cyc < 30);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ack_c, rv_c, ce0, rv0, ra0, n;
        logic [5:0] cmd;
        logic [5:0] order;

        // Reset with both requests pending.
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'd3; r0_wdata = 32'hAABBCCDD; r0_mask = 4'hF;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 10'd4; r1_wdata = 32'h11223344; r1_mask = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_ctl", 64'({r0_ack, r1_ack, r0_rvalid, r1_rvalid, mem_ce, mem_wr_en, busy}), 64'd0);
        check("rst_rdata", 64'({r0_rdata, r1_rdata}), 64'd0);
        check("rst_mem", 64'({mem_addr, mem_wdata, mem_mask}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("first_ack", 64'({r0_ack, r1_ack}), 64'b10);
        check("st_cmd", 64'({mem_ce, mem_wr_en, mem_addr, mem_wdata, mem_mask, busy}),
              64'({1'b1, 1'b1, 10'd3, 32'hAABBCCDD, 4'hF, 1'b1}));
        r0_req = 1'b0;
        @(negedge clk);
        check("st_one_cycle", 64'({mem_ce, mem_wr_en, busy, r0_ack}), 64'd0);
        check("st_hold", 64'({mem_addr, mem_mask}), 64'({10'd3, 4'hF}));
        @(negedge clk);
        check("r1_second", 64'({r0_ack, r1_ack, mem_addr}), 64'({1'b0, 1'b1, 10'd4}));
        r1_req = 1'b0;
        @(negedge clk);

        // Port 0 load of the stored word.
        txn(1'b0, 1'b0, 10'd3, 32'h0, 4'hF, ack_c, rv_c, cmd);
        check("ld_ack_lat", 64'(ack_c), 64'd1);
        check("ld_cmd", 64'(cmd), 64'b10_0000);
        check("ld_rv_lat", 64'(rv_c), 64'd3);
        check("ld_rdata", 64'(r0_rdata), 64'hAABBCCDD);

        // Masked store from port 1, then readback.
        txn(1'b1, 1'b1, 10'd4, 32'h0000EEFF, 4'b0011, ack_c, rv_c, cmd);
        check("mst_cmd", 64'({ack_c[3:0], cmd}), 64'({4'd1, 6'b11_0011}));
        @(negedge clk);
        txn(1'b1, 1'b0, 10'd4, 32'h0, 4'h0, ack_c, rv_c, cmd);
        check("mst_rv_lat", 64'(rv_c), 64'd3);
        check("mst_rdata", 64'(r1_rdata), 64'h1122EEFF);

        // Port isolation plus a request from port 1 dropped while busy.
        txn(1'b0, 1'b1, 10'd5, 32'h00000099, 4'hF, ack_c, rv_c, cmd);
        @(negedge clk);
        ce0 = ce_cnt; rv0 = r1_rv_cnt; ra0 = r1_ack_cnt;
        fork
            txn(1'b0, 1'b0, 10'd5, 32'h0, 4'h0, ack_c, rv_c, cmd);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (r0_ack) break;
                end
                r1_req = 1'b1; r1_we = 1'b1; r1_addr = 10'd9; r1_wdata = 32'hDEAD; r1_mask = 4'hF;
                @(negedge clk);
                r1_req = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check("iso_r0_rdata", 64'(r0_rdata), 64'h99);
        check("iso_r1_rdata", 64'(r1_rdata), 64'h1122EEFF);
        check("iso_r1_rvalid", 64'(r1_rv_cnt - rv0), 64'd0);
        check("drop_no_ack", 64'(r1_ack_cnt - ra0), 64'd0);
        check("drop_no_access", 64'(ce_cnt - ce0), 64'd1);

        // Reset during RDWAIT discards the load.
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'd3;
        @(negedge clk);
        r0_req = 1'b0;
        @(negedge clk);
        check("mid_in_rdwait", 64'({busy, mem_ce}), 64'b10);
        rv0 = r0_rv_cnt;
        #2 rst = 1'b1;
        @(negedge clk);
        check("mid_ctl", 64'({r0_rvalid, busy, mem_ce, mem_wr_en}), 64'd0);
        check("mid_rdata", 64'(r0_rdata), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_no_rvalid", 64'(r0_rv_cnt - rv0), 64'd0);
        txn(1'b1, 1'b1, 10'd6, 32'hCAFEF00D, 4'hF, ack_c, rv_c, cmd);
        check("post_st_ack", 64'(ack_c), 64'd1);
        @(negedge clk);
        txn(1'b0, 1'b0, 10'd6, 32'h0, 4'h0, ack_c, rv_c, cmd);
        check("post_ld", 64'({rv_c[3:0], r0_rdata}), 64'({4'd3, 32'hCAFEF00D}));

        // Arbitration order with both ports requesting continuously.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'd7; r0_wdata = 32'h1; r0_mask = 4'hF;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 10'd8; r1_wdata = 32'h2; r1_mask = 4'hF;
        n = 0;
        order = '0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            @(negedge clk);
            if (r0_ack) begin order[n] = 1'b0; n++; end
            else if (r1_ack) begin order[n] = 1'b1; n++; end
        end
        r0_req = 1'b0; r1_req = 1'b0;
        check("arb_count", 64'(n), 64'd6);
`ifdef MEM_ARB_FIXED_PRIO_EN
        check("arb_order", 64'(order), 64'b000000);
`else
        check("arb_order", 64'(order), 64'b101010);
`endif
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
